// File: rtl/alu_iter_if.sv
// Request/result handshake bundle between register-read and writeback for alu_iter_unit.
interface alu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op_type;
  logic [5:0]       func_field;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             ovf;
  logic             div_by_zero;

  modport master (
    output in_valid, op_type, func_field, a, b, out_ready,
    input  in_ready, out_valid, result, hi, zero, ovf, div_by_zero
  );

  modport slave (
    input  in_valid, op_type, func_field, a, b, out_ready,
    output in_ready, out_valid, result, hi, zero, ovf, div_by_zero
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative ALU: single-cycle arith/logic/shift ops, WIDTH-cycle shift-add multiply
// and restoring unsigned divide, valid/ready on both sides.
module alu_iter_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  alu_iter_if.slave bus
);
  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL, OP_SRL, OP_MUL, OP_DIV
  } op_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] wrk_hi_q, wrk_hi_d, wrk_lo_q, wrk_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  op_e              op_c;
  logic [WIDTH-1:0] sum_c, dif_c, alu_c;
  logic             ovf_c;
  logic [WIDTH:0]   msum_c, dshift_c, ddiff_c;
  logic [WIDTH-1:0] mul_hi_c, mul_lo_c, div_rem_c, div_quo_c;
  logic             div_ge_c;

  // Operation decode from op_type / func_field
  always_comb begin
    op_c = OP_ADD;
    case (bus.op_type)
      2'b01: op_c = OP_SUB;
      2'b10: begin
        case (bus.func_field)
          6'b100010: op_c = OP_SUB;
          6'b100100: op_c = OP_AND;
          6'b100101: op_c = OP_OR;
          6'b100111: op_c = OP_NOR;
          6'b101010: op_c = OP_SLT;
          6'b000000: op_c = OP_SLL;
          6'b000010: op_c = OP_SRL;
          6'b011000: op_c = OP_MUL;
          6'b011011: op_c = OP_DIV;
          default:   op_c = OP_ADD;
        endcase
      end
      default: op_c = OP_ADD;
    endcase
  end

  // Single-cycle datapath
  always_comb begin
    sum_c = bus.a + bus.b;
    dif_c = bus.a - bus.b;
    alu_c = sum_c;
    ovf_c = 1'b0;
    case (op_c)
      OP_ADD: ovf_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_c[WIDTH-1] != bus.a[WIDTH-1]);
      OP_SUB: begin
        alu_c = dif_c;
        ovf_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif_c[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_c = bus.a & bus.b;
      OP_OR:   alu_c = bus.a | bus.b;
      OP_NOR:  alu_c = ~(bus.a | bus.b);
      OP_SLT:  alu_c = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_SLL:  alu_c = bus.a << bus.b[ShW-1:0];
      OP_SRL:  alu_c = bus.a >> bus.b[ShW-1:0];
      default: alu_c = sum_c;
    endcase
  end

  // One multiply / divide iteration; wrk_hi:wrk_lo is product or remainder:quotient
  always_comb begin
    msum_c    = {1'b0, wrk_hi_q} + (wrk_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_c  = msum_c[WIDTH:1];
    mul_lo_c  = {msum_c[0], wrk_lo_q[WIDTH-1:1]};
    dshift_c  = {wrk_hi_q, wrk_lo_q[WIDTH-1]};
    ddiff_c   = dshift_c - {1'b0, opnd_q};
    div_ge_c  = ~ddiff_c[WIDTH];
    div_rem_c = div_ge_c ? ddiff_c[WIDTH-1:0] : dshift_c[WIDTH-1:0];
    div_quo_c = {wrk_lo_q[WIDTH-2:0], div_ge_c};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wrk_hi_d = wrk_hi_q;
    wrk_lo_d = wrk_lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          case (op_c)
            OP_MUL: begin
              state_d  = S_MUL;
              cnt_d    = CntW'(WIDTH);
              wrk_hi_d = '0;
              wrk_lo_d = bus.b;
              opnd_d   = bus.a;
            end
            OP_DIV: begin
              state_d  = S_DIV;
              cnt_d    = CntW'(WIDTH);
              wrk_hi_d = '0;
              wrk_lo_d = bus.a;
              opnd_d   = bus.b;
            end
            default: begin
              state_d  = S_DONE;
              result_d = alu_c;
              hi_d     = '0;
              zero_d   = (alu_c == '0);
              ovf_d    = ovf_c;
              dbz_d    = 1'b0;
            end
          endcase
        end
      end
      S_MUL: begin
        cnt_d    = cnt_q - CntW'(1);
        wrk_hi_d = mul_hi_c;
        wrk_lo_d = mul_lo_c;
        if (cnt_q == CntW'(1)) begin
          state_d  = S_DONE;
          result_d = mul_lo_c;
          hi_d     = mul_hi_c;
          zero_d   = (mul_lo_c == '0);
          ovf_d    = 1'b0;
          dbz_d    = 1'b0;
        end
      end
      S_DIV: begin
        cnt_d    = cnt_q - CntW'(1);
        wrk_hi_d = div_rem_c;
        wrk_lo_d = div_quo_c;
        // A zero divisor naturally yields all-ones quotient and remainder == dividend
        if (cnt_q == CntW'(1)) begin
          state_d  = S_DONE;
          result_d = div_quo_c;
          hi_d     = div_rem_c;
          zero_d   = (div_quo_c == '0);
          ovf_d    = 1'b0;
          dbz_d    = (opnd_q == '0);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wrk_hi_q    <= '0;
      wrk_lo_q    <= '0;
      opnd_q      <= '0;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wrk_hi_q    <= wrk_hi_d;
      wrk_lo_q    <= wrk_lo_d;
      opnd_q      <= opnd_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.zero        = zero_q;
  assign bus.ovf         = ovf_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/alu_iter_unit.md
Name: alu_iter_unit

Overview:
- Parametrised successor to the combinational ALU control decode.
- Decodes the same op_type/func_field encodings internally and executes the operation on WIDTH-bit operands.
- Single-cycle ops complete in 1 cycle. Multiply and unsigned divide run iteratively over WIDTH cycles.
- Sits between the register-read and writeback stages of the multi-cycle MIPS datapath, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand and result width (≥4, power of two). Shift amount is the low log2(WIDTH) bits of b.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request present
- in_ready  output  1  unit can accept a request this cycle
- op_type  input  2  00 imm add, 01 imm sub, 10 R-type, 11 treated as add
- func_field  input  6  R-type function code, ignored unless op_type=10
- a  input  WIDTH  operand A (shift source, dividend, multiplicand)
- b  input  WIDTH  operand B (shift amount, divisor, multiplier)
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer takes the result this cycle
- result  output  WIDTH  primary result
- hi  output  WIDTH  mult: upper product half; divu: remainder; else 0
- zero  output  1  result == 0
- ovf  output  1  signed overflow (add/sub only, else 0)
- div_by_zero  output  1  divu with b == 0

Behaviour:
- Decode, R-type func:
  - 100000 add; 100010 sub; 100100 and; 100101 or; 100111 nor
  - 101010 slt (signed, result 1 or 0); 000000 sll; 000010 srl (logical)
  - 011000 mult (unsigned, 2*WIDTH product); 011011 divu
  - any other func executes as add
- States: IDLE, MUL, DIV, DONE.
- IDLE: in_ready=1. Accept = in_valid && in_ready at a rising edge.
  - Single-cycle op: capture outputs, go to DONE. out_valid is high in the cycle after the accept edge (latency 1).
  - mult: go to MUL and load an iteration counter with WIDTH.
  - divu: go to DIV and load an iteration counter with WIDTH.
- MUL: shift-add, one multiplier bit per cycle. The counter decrements. On the edge where it reaches 0, go to DONE with result=product[WIDTH-1:0] and hi=product[2*WIDTH-1:WIDTH]. out_valid rises exactly WIDTH cycles after the accept edge.
- DIV: restoring divide, one quotient bit per cycle, same WIDTH-cycle latency. Result=quotient, hi=remainder.
  - If b==0 at accept: still run WIDTH cycles; deliver result=all ones, hi=a, div_by_zero=1.
- DONE: out_valid=1, in_ready=0. Outputs stay stable until out_ready. If out_ready=1, go to IDLE at that edge and clear out_valid. No new accept in the same cycle; single-cycle throughput is 1 op per 2 cycles.
- in_ready=0 in MUL, DIV and DONE. Requests there are not accepted and must be held by the producer.
- Operands and decoded op are registered at accept. Later changes on a, b, op_type and func_field do not affect an in-flight operation.
- Flags:
  - zero computed from the final result.
  - ovf=1 when add operands share a sign and the sum differs, or sub operands differ in sign and the difference sign differs from a.
  - ovf=0 for all non-add/sub ops. div_by_zero=0 for non-divu ops.
- Shifts use b[log2(WIDTH)-1:0] only; upper bits of b are ignored.
- Reset (any state, including mid-MUL/DIV):
  - next state IDLE, in-flight op discarded
  - out_valid=0; result, hi, zero, ovf, div_by_zero = 0; counter = 0
  - in_ready=1 in the cycle after reset deasserts
- Wrap-around: add/sub results are modulo 2^WIDTH; ovf only flags the signed condition.

Test Plan:
- Reset: hold rst 2 cycles, then release with in_valid=0 → out_valid=0, result=0, in_ready=1.
- Add: op_type=10, func=100000, a=0x7FFFFFFF, b=1 → one cycle later out_valid=1, result=0x80000000, ovf=1, zero=0. Repeat with op_type=00, a=5, b=0xFFFFFFFB → result=0, zero=1, ovf=0.
- Mult: func=011000, a=0xFFFFFFFF, b=2 → out_valid exactly 32 cycles after accept, result=0xFFFFFFFE, hi=1, in_ready=0 throughout. With out_ready=0 for 5 extra cycles, outputs stay stable.
- Divu: func=011011, a=100, b=7 → result=14, hi=2. Then a=9, b=0 → result=0xFFFFFFFF, hi=9, div_by_zero=1.
- Shifts and slt: sll a=1, b=0x23 → result=8 (only low 5 bits used). srl a=0x80000000, b=31 → 1. slt a=0xFFFFFFFF, b=1 → 1.
- Reset mid-op and decode: start mult, assert rst at cycle 10 → no out_valid and in_ready=1 after release. Unknown func 111111 with a=3, b=4 → result=7. With WIDTH=8, mult a=0xFF, b=0xFF → 8-cycle latency, result=0x01, hi=0xFE.
